// File: rtl/if_id_skid_pkg.sv
// Shared constants and types for the fetch/decode boundary buffer.
// Decode imports the same constants so NOP and depth stay consistent.
package if_id_skid_pkg;

  localparam int          DEF_XLEN     = 32;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam int          IF_ID_DEPTH  = 2;              // legal: 2 or 4

  typedef struct packed {
    logic exp_flag;
    logic inst_addr_misal;
  } fetch_flags_t;

  localparam int FLAGS_W = $bits(fetch_flags_t);

  function automatic int entry_width(input int xlen);
    return 2 * xlen + FLAGS_W;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_id_skid_if.sv
// Stage-to-stage valid/allowin bus carrying {pc, inst, exception flags}.
// The producer side is the master; the consumer drives allowin back.
interface if_id_skid_if
  import if_id_skid_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) ();

  logic            valid;
  logic            allowin;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inst;
  logic            exp_flag;
  logic            inst_addr_misal;

  modport master (
    output valid,
    output pc,
    output inst,
    output exp_flag,
    output inst_addr_misal,
    input  allowin
  );

  modport slave (
    input  valid,
    input  pc,
    input  inst,
    input  exp_flag,
    input  inst_addr_misal,
    output allowin
  );

endinterface

// File: rtl/if_id_skid_fifo.sv
// Generic circular FIFO with occupancy count, push/pop and single-cycle flush.
// Storage is not reset; only pointers and count carry valid state.
module skid_fifo
  import if_id_skid_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_id_skid.sv
// IF/ID boundary: buffers fetched entries in a skid FIFO, decodes flush and
// stall, and inserts a NOP toward decode whenever the buffer is empty.
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter  int              XLEN     = DEF_XLEN,
  parameter  int              DEPTH    = IF_ID_DEPTH,
  parameter  logic [XLEN-1:0] NOP_INST = XLEN'(DEF_NOP_INST),
  localparam int              CNT_W    = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  if_id_skid_if.slave      if_bus,
  if_id_skid_if.master     id_bus,
  input  logic             pipe_stall,
  input  logic             bj_flag,
  input  logic             jump2exp,
  input  logic             ex_is_mret_inst,
  output logic [CNT_W-1:0] occupancy
);

  localparam int ENTRY_W = entry_width(XLEN);

  logic               flush;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;
  logic [XLEN-1:0]    head_pc;
  logic [XLEN-1:0]    head_inst;
  fetch_flags_t       wflags;
  fetch_flags_t       rflags;

  assign flush = bj_flag | jump2exp | ex_is_mret_inst;

  // Allowin looks only at registered occupancy, so a pop on a full buffer
  // does not open the fetch side until the following cycle.
  assign if_bus.allowin = ~rst & ~full;

  assign push = if_bus.valid & if_bus.allowin & ~flush;
  assign pop  = id_bus.valid & id_bus.allowin & ~pipe_stall & ~flush;

  assign wflags.exp_flag        = if_bus.exp_flag;
  assign wflags.inst_addr_misal = if_bus.inst_addr_misal;
  assign wdata = {if_bus.pc, if_bus.inst, wflags};

  skid_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .rdata (rdata),
    .count (occupancy),
    .full  (full),
    .empty (empty)
  );

  assign {head_pc, head_inst, rflags} = rdata;

  // Empty slots hold stale data; mask so decode sees a clean bubble.
  assign id_bus.valid           = ~empty;
  assign id_bus.pc              = empty ? '0 : head_pc;
  assign id_bus.inst            = empty ? NOP_INST : head_inst;
  assign id_bus.exp_flag        = ~empty & rflags.exp_flag;
  assign id_bus.inst_addr_misal = ~empty & rflags.inst_addr_misal;

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed scenarios then random traffic, all checked
// against a queue-based model of the buffer contents.
module tb_if_id_skid;
  import if_id_skid_pkg::*;

  localparam int          DEPTH = 2;
  localparam int          XL    = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pipe_stall = 1'b0;
  logic       bj_flag = 1'b0;
  logic       jump2exp = 1'b0;
  logic       ex_is_mret_inst = 1'b0;
  logic [1:0] occupancy;

  if_id_skid_if #(.XLEN(XL)) if_bus ();
  if_id_skid_if #(.XLEN(XL)) id_bus ();

  always #5 clk = ~clk;

  if_id_skid #(.XLEN(XL), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_bus          (if_bus),
    .id_bus          (id_bus),
    .pipe_stall      (pipe_stall),
    .bj_flag         (bj_flag),
    .jump2exp        (jump2exp),
    .ex_is_mret_inst (ex_is_mret_inst),
    .occupancy       (occupancy)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ef;
    logic        mis;
  } ent_t;

  ent_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model to the state the coming edge should produce.
  task automatic step(input logic r, input logic v, input logic [31:0] pc,
                      input logic [31:0] inst, input logic ef, input logic mis,
                      input logic ia, input logic st, input logic bj,
                      input logic je, input logic mr);
    logic exp_allow;
    logic exp_v;
    ent_t e;
    @(negedge clk);
    rst                    = r;
    if_bus.valid           = v;
    if_bus.pc              = pc;
    if_bus.inst            = inst;
    if_bus.exp_flag        = ef;
    if_bus.inst_addr_misal = mis;
    id_bus.allowin         = ia;
    pipe_stall             = st;
    bj_flag                = bj;
    jump2exp               = je;
    ex_is_mret_inst        = mr;
    #1;
    exp_allow = !r && (q.size() < DEPTH);
    exp_v     = (q.size() > 0);
    chk("if_id_valid", 64'(if_bus.allowin), 64'(exp_allow));
    chk("id_valid", 64'(id_bus.valid), 64'(exp_v));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("id_inst", 64'(id_bus.inst), 64'(exp_v ? q[0].inst : NOP));
    chk("id_exp_flag", 64'(id_bus.exp_flag), 64'(exp_v ? q[0].ef : 1'b0));
    chk("id_misal", 64'(id_bus.inst_addr_misal), 64'(exp_v ? q[0].mis : 1'b0));
    if (exp_v) chk("id_pc", 64'(id_bus.pc), 64'(q[0].pc));
    if (r || bj || je || mr) begin
      q.delete();
    end else begin
      if (exp_v && ia && !st) void'(q.pop_front());
      if (v && exp_allow) begin
        e.pc = pc; e.inst = inst; e.ef = ef; e.mis = mis;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic ia, input logic st);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, ia, st, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic put(input logic [31:0] pc, input logic ia, input logic st);
    step(1'b0, 1'b1, pc, pc ^ 32'hA5A5_0000, 1'b0, 1'b0, ia, st, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    if_bus.valid = 1'b0; if_bus.pc = '0; if_bus.inst = '0;
    if_bus.exp_flag = 1'b0; if_bus.inst_addr_misal = 1'b0;
    id_bus.allowin = 1'b0;

    // reset then idle
    repeat (3) step(1'b1, 1'b1, 32'h40, 32'h1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_id_pc", 64'(id_bus.pc), 64'h0);
    chk("rst_id_inst", 64'(id_bus.inst), 64'(NOP));
    idle(1'b1, 1'b0);
    chk("post_rst_allow", 64'(if_bus.allowin), 64'h1);

    // streaming
    put(32'h0, 1'b1, 1'b0);
    put(32'h4, 1'b1, 1'b0);
    chk("stream_pc0", 64'(id_bus.pc), 64'h0);
    put(32'h8, 1'b1, 1'b0);
    chk("stream_pc4", 64'(id_bus.pc), 64'h4);
    idle(1'b1, 1'b0);
    chk("stream_pc8", 64'(id_bus.pc), 64'h8);
    idle(1'b1, 1'b0);

    // backpressure until full
    put(32'h0, 1'b0, 1'b0);
    put(32'h4, 1'b0, 1'b0);
    put(32'h8, 1'b0, 1'b0);
    chk("full_occ", 64'(occupancy), 64'h2);
    chk("full_allow", 64'(if_bus.allowin), 64'h0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    chk("drain_pc4", 64'(id_bus.pc), 64'h4);
    idle(1'b1, 1'b0);

    // flush with simultaneous push
    put(32'h0, 1'b0, 1'b0);
    put(32'h4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h100, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    put(32'h200, 1'b0, 1'b0);
    chk("flush_occ", 64'(occupancy), 64'h0);
    chk("flush_valid", 64'(id_bus.valid), 64'h0);
    idle(1'b0, 1'b0);
    chk("flush_head", 64'(id_bus.pc), 64'h200);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // pipe_stall blocks pop, not push
    put(32'h10, 1'b0, 1'b0);
    put(32'h14, 1'b1, 1'b1);
    put(32'h18, 1'b1, 1'b1);
    chk("stall_head", 64'(id_bus.pc), 64'h10);
    chk("stall_occ", 64'(occupancy), 64'h2);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    chk("stall_order", 64'(id_bus.pc), 64'h14);
    idle(1'b1, 1'b0);

    // exception flags carried unchanged
    step(1'b0, 1'b1, 32'h6, 32'h13579BDF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    chk("exc_flag", 64'(id_bus.exp_flag), 64'h1);
    chk("exc_misal", 64'(id_bus.inst_addr_misal), 64'h1);
    chk("exc_pc", 64'(id_bus.pc), 64'h6);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    chk("exc_clear", 64'(id_bus.exp_flag), 64'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           $urandom & 32'hFFFF_FFFE,
           $urandom,
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 59) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
